// File: rtl/alignment_output_packer_pkg.sv
// Shared constants and FSM state type for the alignment output packer.
// Derived widths here correspond to the default parameter set.
package alignment_output_packer_pkg;

  localparam int DEF_LETTER_WIDTH = 2;
  localparam int DEF_SCORE_WIDTH  = 10;
  localparam int DEF_SEQ_LENGTH   = 32;
  localparam int DEF_PACK_N       = 4;
  localparam int DEF_FIFO_DEPTH   = 8;

  localparam int PAIR_W = 2 * (DEF_LETTER_WIDTH + 1);
  localparam int OUT_W  = DEF_PACK_N * PAIR_W;
  localparam int LEN_W  = $clog2(2 * DEF_SEQ_LENGTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    TRAILER = 2'd3
  } packer_state_t;

endpackage

// File: rtl/align_word_fifo.sv
// Synchronous word FIFO with full/empty flags; a pop in the same cycle frees
// a slot for a push even when full. Head reads as zero while empty.
module align_word_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alignment_output_packer.sv
// Packs traceback symbol pairs into fixed-width words, closes each frame with
// a trailer (pair count, score, overflow flag) and buffers words for the host.
module alignment_output_packer
  import alignment_output_packer_pkg::*;
#(
  parameter int LETTER_WIDTH = DEF_LETTER_WIDTH,
  parameter int SCORE_WIDTH  = DEF_SCORE_WIDTH,
  parameter int SEQ_LENGTH   = DEF_SEQ_LENGTH,
  parameter int PACK_N       = DEF_PACK_N,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    output_valid,
  input  logic [LETTER_WIDTH:0]                   query_seq_out,
  input  logic [LETTER_WIDTH:0]                   database_seq_out,
  input  logic [SCORE_WIDTH-1:0]                  score,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PACK_N*2*(LETTER_WIDTH+1)-1:0]    out_data,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    frame_err
);

  localparam int SYM_W     = LETTER_WIDTH + 1;
  localparam int PAIR_BITS = 2 * SYM_W;
  localparam int WORD_W    = PACK_N * PAIR_BITS;
  localparam int CNT_W     = $clog2(2 * SEQ_LENGTH + 1);
  localparam int SLOT_W    = (PACK_N > 1) ? $clog2(PACK_N) : 1;

  generate
    if (WORD_W < SCORE_WIDTH + CNT_W + 1) begin : g_width_check
      $error("alignment_output_packer: word too narrow for trailer");
    end
  endgenerate

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  packer_state_t          state;
  logic [WORD_W-1:0]      acc;
  logic [SLOT_W-1:0]      slot;
  logic [CNT_W-1:0]       pair_count;
  logic [SCORE_WIDTH-1:0] score_q;
  logic                   ovf;

  logic [PAIR_BITS-1:0]   pair;
  logic [WORD_W-1:0]      acc_ins;
  logic [WORD_W-1:0]      trailer;
  logic                   word_done;
  logic                   fifo_push;
  logic [WORD_W:0]        fifo_din;
  logic [WORD_W:0]        fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   can_push;

  assign pair      = {database_seq_out, query_seq_out};
  assign acc_ins   = acc | (WORD_W'(pair) << (PAIR_BITS * slot));
  assign word_done = (slot == SLOT_W'(PACK_N - 1));
  assign pop       = out_valid && out_ready;
  assign can_push  = !fifo_full || pop;

  always_comb begin
    trailer                        = '0;
    trailer[CNT_W-1:0]             = pair_count;
    trailer[CNT_W +: SCORE_WIDTH]  = score_q;
    trailer[WORD_W-1]              = ovf;
  end

  always_comb begin
    fifo_push = 1'b0;
    fifo_din  = '0;
    case (state)
      IDLE, COLLECT: begin
        fifo_push = output_valid && word_done;
        fifo_din  = {1'b0, acc_ins};
      end
      FLUSH: begin
        fifo_push = (slot != '0);
        fifo_din  = {1'b0, acc};
      end
      TRAILER: begin
        fifo_push = 1'b1;
        fifo_din  = {1'b1, trailer};
      end
      default: ;
    endcase
  end

  // A full word arriving while the FIFO is full is dropped and flagged;
  // flush and trailer pushes stall instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      slot       <= '0;
      pair_count <= '0;
      score_q    <= '0;
      ovf        <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (output_valid) begin
            state      <= COLLECT;
            score_q    <= score;
            pair_count <= sat_inc(pair_count);
            if (word_done) begin
              acc  <= '0;
              slot <= '0;
              if (!can_push) begin
                ovf       <= 1'b1;
                frame_err <= 1'b1;
              end
            end else begin
              acc  <= acc_ins;
              slot <= slot + 1'b1;
            end
          end else if (state == COLLECT) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (output_valid) frame_err <= 1'b1;
          if (slot == '0) begin
            state <= TRAILER;
          end else if (can_push) begin
            acc   <= '0;
            slot  <= '0;
            state <= TRAILER;
          end
        end
        TRAILER: begin
          if (output_valid) frame_err <= 1'b1;
          if (can_push) begin
            acc        <= '0;
            slot       <= '0;
            pair_count <= '0;
            score_q    <= '0;
            ovf        <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  align_word_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = fifo_dout[WORD_W];
  assign out_data  = fifo_dout[WORD_W-1:0];
  assign busy      = (state == FLUSH) || (state == TRAILER);

endmodule

// File: tb/tb_alignment_output_packer.sv
// Randomized and directed bench for alignment_output_packer, scored against a
// frame-level model of the expected word stream.
module tb_alignment_output_packer;

  localparam int PACK  = 4;
  localparam int OUTW  = 24;
  localparam int LENW  = 7;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        output_valid = 1'b0;
  logic [2:0]  query_seq_out = '0;
  logic [2:0]  database_seq_out = '0;
  logic [9:0]  score = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_last;
  logic        busy;
  logic        frame_err;

  always #5 clk = ~clk;

  alignment_output_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .output_valid     (output_valid),
    .query_seq_out    (query_seq_out),
    .database_seq_out (database_seq_out),
    .score            (score),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .frame_err        (frame_err)
  );

  typedef struct {
    logic [23:0] data;
    logic        last;
  } item_t;

  item_t      exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         ready_mode = 0;
  logic [2:0] pq [64];
  logic [2:0] pd [64];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
    end
  endtask

  // Expected words of one frame: pairs packed PACK per word in arrival order,
  // full words past 'kept' are lost, then the trailer.
  task automatic model_frame(input int n, input int sc, input int kept);
    int          nw;
    logic        ovf;
    logic [23:0] word;
    logic [23:0] tr;
    item_t       it;
    nw  = (n + PACK - 1) / PACK;
    ovf = 1'b0;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int j = 0; j < PACK; j++) begin
        if (w * PACK + j < n)
          word = word | (24'({pd[w*PACK+j], pq[w*PACK+j]}) << (6 * j));
      end
      if (w < kept) begin
        it.data = word;
        it.last = 1'b0;
        exp_q.push_back(it);
      end else begin
        ovf = 1'b1;
      end
    end
    tr = 24'((n > 127) ? 127 : n) | (24'(sc) << LENW) | (ovf ? 24'h800000 : 24'h0);
    it.data = tr;
    it.last = 1'b1;
    exp_q.push_back(it);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      pq[i] = 3'($urandom_range(0, 7));
      pd[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic send_frame(input int n, input int sc, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      output_valid     = 1'b1;
      query_seq_out    = pq[i];
      database_seq_out = pd[i];
      score            = 10'(sc);
      @(posedge clk); #1;
      if (chk_lat && i == PACK - 2) chk("latency_before", out_valid, 1'b0);
      if (chk_lat && i == PACK - 1) chk("latency_word", out_valid, 1'b1);
    end
    output_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b1;
    output_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  initial begin
    logic        hold_pending;
    logic [24:0] held;
    item_t       e;
    hold_pending = 1'b0;
    held         = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_word", {out_last, out_data}, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", {out_last, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", out_data, e.data);
            chk("word_last", out_last, e.last);
          end
        end
        hold_pending = out_valid && !out_ready;
        held         = {out_last, out_data};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int sc;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 24'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);

    // Six pairs: full word, partial word, trailer.
    for (int i = 0; i < 6; i++) begin
      pq[i] = 3'(i + 1);
      pd[i] = 3'd0;
    end
    model_frame(6, 37, 99);
    send_frame(6, 37, 1'b1);
    wait_drain(200);
    chk("t1_frame_err", frame_err, 1'b0);

    // Exactly one full word: no zero-padded word.
    for (int i = 0; i < 4; i++) begin
      pq[i] = 3'(i + 4);
      pd[i] = 3'(7 - i);
    end
    model_frame(4, 12, 99);
    send_frame(4, 12, 1'b0);
    wait_drain(200);

    // Backpressure overflow: 8 words kept, 2 dropped.
    ready_mode = 1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    fill_random(40);
    model_frame(40, 500, DEPTH);
    send_frame(40, 500, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("ovf_busy", busy, 1'b1);
    chk("ovf_frame_err", frame_err, 1'b1);
    chk("ovf_out_valid", out_valid, 1'b1);
    chk("ovf_head_last", out_last, 1'b0);
    ready_mode = 0;
    wait_drain(300);
    chk("ovf_err_sticky", frame_err, 1'b1);
    do_reset();
    chk("ovf_err_cleared", frame_err, 1'b0);

    // Consumer toggling every cycle.
    ready_mode = 2;
    fill_random(12);
    model_frame(12, 777, 99);
    send_frame(12, 777, 1'b0);
    wait_drain(300);
    chk("toggle_frame_err", frame_err, 1'b0);
    ready_mode = 0;

    // Reset at the third pair of a ten-pair frame, then a fresh frame.
    fill_random(10);
    send_frame(2, 99, 1'b0);
    output_valid     = 1'b1;
    query_seq_out    = pq[2];
    database_seq_out = pd[2];
    rst_n            = 1'b1;
    @(posedge clk); #1;
    output_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_data", out_data, 24'h0);
    fill_random(2);
    model_frame(2, 321, 99);
    send_frame(2, 321, 1'b0);
    wait_drain(200);

    // Stray pair while busy: ignored, flagged, trailer unchanged.
    fill_random(6);
    model_frame(6, 200, 99);
    send_frame(6, 200, 1'b0);
    @(posedge clk); #1;
    chk("stray_busy", busy, 1'b1);
    output_valid     = 1'b1;
    query_seq_out    = 3'd7;
    database_seq_out = 3'd7;
    score            = 10'd5;
    @(posedge clk); #1;
    output_valid = 1'b0;
    chk("stray_frame_err", frame_err, 1'b1);
    wait_drain(200);

    // Random frames with random backpressure; short enough never to overflow.
    do_reset();
    ready_mode = 3;
    for (int f = 0; f < 20; f++) begin
      n  = $urandom_range(1, 28);
      sc = $urandom_range(0, 1023);
      fill_random(n);
      model_frame(n, sc, 99);
      send_frame(n, sc, 1'b0);
      wait_drain(600);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    chk("rand_frame_err", frame_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
